bram_tdp_36k: RTL and testbench

//  Behavioural true-dual-port 36 Kb block RAM (1024 x 32 data + 4 parity bits), both ports on one clock.

---
 rtl/bram_tdp_36k_pkg.sv | 35 +++
 rtl/bram_tdp_36k_port.sv | 71 +++++++
 rtl/bram_tdp_36k.sv | 163 ++++++++++++++++
 tb/tb_bram_tdp_36k.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_tdp_36k_pkg.sv
// Shared definitions for the 36 Kb true-dual-port block RAM.
//   WORDS / AW  : array depth and word-address width
//   DW          : stored word width, {4 parity bits, 32 data bits}
//   wmode_e     : per-port read-during-write behaviour of the output latch
//   merge_word  : byte-lane merge of write data into an existing word
package bram_tdp_36k_pkg;

  localparam int WORDS  = 1024;
  localparam int AW     = 10;
  localparam int DW     = 36;
  localparam int NBYTES = 4;

  typedef enum logic [1:0] {
    WM_WRITE_FIRST = 2'd0,
    WM_READ_FIRST  = 2'd1,
    WM_NO_CHANGE   = 2'd2
  } wmode_e;

  // Lane i owns data bits [8i+7:8i] and parity bit 32+i; only enabled lanes
  // take the new value, the rest keep the old word.
  function automatic logic [DW-1:0] merge_word(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [NBYTES-1:0] be);
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
        res[32 + i]   = new_w[32 + i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_tdp_36k_port.sv
// Output side of one RAM port: the read latch and the optional output register.
//   clk_i, rst_i   : clock, synchronous active-high reset (loads INIT)
//   en_i           : port enable; when low the latch holds
//   wr_i           : at least one byte-write enable set this cycle
//   ssr_i          : synchronous set/reset of latch and output register to SRVAL
//   regce_i        : output register clock enable
//   old_word_i     : word at the port address before this edge
//   new_word_i     : same word merged with this port's write data
//   dout_o         : {parity, data} seen by the user
module bram_tdp_36k_port
  import bram_tdp_36k_pkg::*;
#(
  parameter logic [DW-1:0] INIT   = '0,
  parameter logic [DW-1:0] SRVAL  = '0,
  parameter int            DO_REG = 0,
  parameter wmode_e        MODE   = WM_WRITE_FIRST
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          wr_i,
  input  logic          ssr_i,
  input  logic          regce_i,
  input  logic [DW-1:0] old_word_i,
  input  logic [DW-1:0] new_word_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] lat_q, lat_d;
  logic [DW-1:0] reg_q, reg_d;

  always_comb begin
    lat_d = lat_q;
    if (en_i) begin
      if (ssr_i) begin
        // Set/reset wins over the read result; the array write is unaffected.
        lat_d = SRVAL;
      end else if (wr_i) begin
        case (MODE)
          WM_WRITE_FIRST: lat_d = new_word_i;
          WM_READ_FIRST:  lat_d = old_word_i;
          default:        lat_d = lat_q;
        endcase
      end else begin
        lat_d = old_word_i;
      end
    end

    // The register samples the latch as it was before this edge, which is
    // what gives the second cycle of latency.
    reg_d = reg_q;
    if (ssr_i) begin
      reg_d = SRVAL;
    end else if (regce_i) begin
      reg_d = lat_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_q <= INIT;
      reg_q <= INIT;
    end else begin
      lat_q <= lat_d;
      reg_q <= reg_d;
    end
  end

  assign dout_o = (DO_REG != 0) ? reg_q : lat_q;

endmodule

// File: rtl/bram_tdp_36k.sv
// Behavioural true-dual-port 36 Kb block RAM, 1024 x (32 data + 4 parity),
// both ports on sys_clk. Port A is the host side, port B the AES datapath.
//   sys_clk, sys_rst            : clock, synchronous active-high reset
//   ena/enb                     : port enable
//   wea/web [3:0]               : byte-lane write enables (data byte + parity bit)
//   addra/addrb [15:0]          : word address in bits [14:5], other bits ignored
//   dia/dib [31:0], dipa/dipb   : write data / parity
//   doa/dob [31:0], dopa/dopb   : read data / parity
//   regcea/regceb               : output register enable (DOx_REG=1 only)
//   ssra/ssrb                   : synchronous output set/reset to SRVAL_x
// Reset reloads the output latches/registers and blocks writes, but never
// touches the array contents.
module bram_tdp_36k
  import bram_tdp_36k_pkg::*;
#(
  parameter int          READ_WIDTH_A  = 36,
  parameter int          READ_WIDTH_B  = 36,
  parameter int          WRITE_WIDTH_A = 36,
  parameter int          WRITE_WIDTH_B = 36,
  parameter int          DOA_REG       = 0,
  parameter int          DOB_REG       = 0,
  parameter logic [35:0] INIT_A        = 36'h0,
  parameter logic [35:0] INIT_B        = 36'h0,
  parameter logic [35:0] SRVAL_A       = 36'h0,
  parameter logic [35:0] SRVAL_B       = 36'h0,
  parameter string       WRITE_MODE_A  = "WRITE_FIRST",
  parameter string       WRITE_MODE_B  = "WRITE_FIRST",
  parameter string       SIM_MODE      = "SAFE"
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ena,
  input  logic [3:0]  wea,
  input  logic [15:0] addra,
  input  logic [31:0] dia,
  input  logic [3:0]  dipa,
  output logic [31:0] doa,
  output logic [3:0]  dopa,
  input  logic        regcea,
  input  logic        ssra,
  input  logic        enb,
  input  logic [3:0]  web,
  input  logic [15:0] addrb,
  input  logic [31:0] dib,
  input  logic [3:0]  dipb,
  output logic [31:0] dob,
  output logic [3:0]  dopb,
  input  logic        regceb,
  input  logic        ssrb
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  localparam bit MODE_A_OK = (WRITE_MODE_A == "WRITE_FIRST") ||
                             (WRITE_MODE_A == "READ_FIRST")  ||
                             (WRITE_MODE_A == "NO_CHANGE");
  localparam bit MODE_B_OK = (WRITE_MODE_B == "WRITE_FIRST") ||
                             (WRITE_MODE_B == "READ_FIRST")  ||
                             (WRITE_MODE_B == "NO_CHANGE");

  localparam wmode_e MODE_A = (WRITE_MODE_A == "READ_FIRST") ? WM_READ_FIRST :
                              (WRITE_MODE_A == "NO_CHANGE")  ? WM_NO_CHANGE  :
                                                               WM_WRITE_FIRST;
  localparam wmode_e MODE_B = (WRITE_MODE_B == "READ_FIRST") ? WM_READ_FIRST :
                              (WRITE_MODE_B == "NO_CHANGE")  ? WM_NO_CHANGE  :
                                                               WM_WRITE_FIRST;

  // SIM_MODE only exists so existing instantiations keep elaborating.
  localparam bit unused_sim_mode = (SIM_MODE == "SAFE");

  if (READ_WIDTH_A != 36 || READ_WIDTH_B != 36 ||
      WRITE_WIDTH_A != 36 || WRITE_WIDTH_B != 36) begin : g_bad_width
    $error("bram_tdp_36k: only 36-bit port widths are supported");
  end

  if (!MODE_A_OK || !MODE_B_OK) begin : g_bad_mode
    $error("bram_tdp_36k: WRITE_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
  end

  // ---------------------------------------------------------------------------
  // Array and write path
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem_q [0:WORDS-1] = '{default: '0};

  logic [AW-1:0] word_a, word_b;
  logic          wr_a, wr_b, both_same;
  logic [DW-1:0] old_a, old_b;
  logic [DW-1:0] merged_a, merged_b, merged_both;
  logic [DW-1:0] dout_a, dout_b;
  logic          unused_addr_bits;

  assign word_a = addra[14:5];
  assign word_b = addrb[14:5];
  assign unused_addr_bits = ^{addra[15], addra[4:0], addrb[15], addrb[4:0]};

  assign wr_a      = ena & (|wea);
  assign wr_b      = enb & (|web);
  assign both_same = wr_a & wr_b & (word_a == word_b);

  // Pre-edge contents: a port reading a word the other port writes on the
  // same edge therefore sees the old word.
  assign old_a = mem_q[word_a];
  assign old_b = mem_q[word_b];

  assign merged_a = merge_word(old_a, {dipa, dia}, wea);
  assign merged_b = merge_word(old_b, {dipb, dib}, web);
  // Same-word double write: lay port B over port A's merge so lanes written
  // by both take B's data while A-only lanes survive.
  assign merged_both = merge_word(merged_a, {dipb, dib}, web);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      if (wr_a && !both_same) begin
        mem_q[word_a] <= merged_a;
      end
      if (wr_b) begin
        mem_q[word_b] <= both_same ? merged_both : merged_b;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output latches / registers
  // ---------------------------------------------------------------------------
  bram_tdp_36k_port #(
    .INIT   (INIT_A),
    .SRVAL  (SRVAL_A),
    .DO_REG (DOA_REG),
    .MODE   (MODE_A)
  ) u_port_a (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .en_i       (ena),
    .wr_i       (|wea),
    .ssr_i      (ssra),
    .regce_i    (regcea),
    .old_word_i (old_a),
    .new_word_i (merged_a),
    .dout_o     (dout_a)
  );

  bram_tdp_36k_port #(
    .INIT   (INIT_B),
    .SRVAL  (SRVAL_B),
    .DO_REG (DOB_REG),
    .MODE   (MODE_B)
  ) u_port_b (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .en_i       (enb),
    .wr_i       (|web),
    .ssr_i      (ssrb),
    .regce_i    (regceb),
    .old_word_i (old_b),
    .new_word_i (merged_b),
    .dout_o     (dout_b)
  );

  assign {dopa, doa} = dout_a;
  assign {dopb, dob} = dout_b;

endmodule

// File: tb/tb_bram_tdp_36k.sv
module tb_bram_tdp_36k;

  // Instance 0: unregistered, A WRITE_FIRST, B READ_FIRST.
  localparam logic [35:0] INIT_A0  = 36'hA_5A5A_0001;
  localparam logic [35:0] INIT_B0  = 36'h5_0000_BEEF;
  localparam logic [35:0] SRVAL_A0 = 36'h3_1234_5678;
  localparam logic [35:0] SRVAL_B0 = 36'hC_CAFE_F00D;
  // Instance 1: registered outputs, A NO_CHANGE, B WRITE_FIRST.
  localparam logic [35:0] INIT_A1  = 36'h0_0000_0077;
  localparam logic [35:0] INIT_B1  = 36'h0_0000_0088;
  localparam logic [35:0] SRVAL_A1 = 36'hF_0000_00AA;
  localparam logic [35:0] SRVAL_B1 = 36'hF_0000_00BB;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  logic        ena, enb, regcea, regceb, ssra, ssrb;
  logic [3:0]  wea, web, dipa, dipb;
  logic [15:0] addra, addrb;
  logic [31:0] dia, dib;
  logic [31:0] doa0, dob0, doa1, dob1;
  logic [3:0]  dopa0, dopb0, dopa1, dopb1;

  bram_tdp_36k #(
    .INIT_A(INIT_A0), .INIT_B(INIT_B0), .SRVAL_A(SRVAL_A0), .SRVAL_B(SRVAL_B0),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"),
    .DOA_REG(0), .DOB_REG(0)
  ) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .dipa(dipa),
    .doa(doa0), .dopa(dopa0), .regcea(regcea), .ssra(ssra),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dipb(dipb),
    .dob(dob0), .dopb(dopb0), .regceb(regceb), .ssrb(ssrb)
  );

  bram_tdp_36k #(
    .INIT_A(INIT_A1), .INIT_B(INIT_B1), .SRVAL_A(SRVAL_A1), .SRVAL_B(SRVAL_B1),
    .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("WRITE_FIRST"),
    .DOA_REG(1), .DOB_REG(1)
  ) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .dipa(dipa),
    .doa(doa1), .dopa(dopa1), .regcea(regcea), .ssra(ssra),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dipb(dipb),
    .dob(dob1), .dopb(dopb1), .regceb(regceb), .ssrb(ssrb)
  );

  // ---------------- reference model ----------------
  // Modes: 0 = write-first, 1 = read-first, 2 = no-change. Index [dut][port].
  logic [35:0] m_mem [0:1023];
  logic [35:0] m_lat [0:1][0:1];
  logic [35:0] m_reg [0:1][0:1];
  logic [35:0] p_init [0:1][0:1];
  logic [35:0] p_srval [0:1][0:1];
  int          p_mode [0:1][0:1];
  int          p_doreg [0:1][0:1];

  logic [35:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [15:0] mk_addr(input logic [9:0] w, input bit junk);
    logic [15:0] a;
    a = {1'b0, w, 5'b0};
    if (junk) begin
      a[15]  = 1'($urandom_range(0, 1));
      a[4:0] = 5'($urandom_range(0, 31));
    end
    return a;
  endfunction

  // Applies this cycle's inputs to the model and queues the four outputs
  // expected just after the coming edge.
  task automatic model_step();
    logic        en [0:1];
    logic        ssr [0:1];
    logic        rce [0:1];
    logic [3:0]  we [0:1];
    logic [9:0]  w [0:1];
    logic [35:0] din [0:1];
    logic [35:0] old [0:1];
    logic [35:0] own [0:1];
    logic [35:0] prev_lat;
    en[0] = ena;  ssr[0] = ssra; rce[0] = regcea; we[0] = wea; w[0] = addra[14:5]; din[0] = {dipa, dia};
    en[1] = enb;  ssr[1] = ssrb; rce[1] = regceb; we[1] = web; w[1] = addrb[14:5]; din[1] = {dipb, dib};
    if (sys_rst) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          m_lat[d][p] = p_init[d][p];
          m_reg[d][p] = p_init[d][p];
        end
    end else begin
      for (int p = 0; p < 2; p++) begin
        old[p] = m_mem[w[p]];
        own[p] = old[p];
        for (int i = 0; i < 4; i++)
          if (we[p][i]) begin
            own[p][8*i +: 8] = din[p][8*i +: 8];
            own[p][32 + i]   = din[p][32 + i];
          end
      end
      // A's lanes first, then B's: B wins any lane both ports write.
      for (int p = 0; p < 2; p++)
        if (en[p])
          for (int i = 0; i < 4; i++)
            if (we[p][i]) begin
              m_mem[w[p]][8*i +: 8] = din[p][8*i +: 8];
              m_mem[w[p]][32 + i]   = din[p][32 + i];
            end
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          prev_lat = m_lat[d][p];
          if (en[p]) begin
            if (ssr[p])              m_lat[d][p] = p_srval[d][p];
            else if (we[p] != 4'h0) begin
              if (p_mode[d][p] == 0)      m_lat[d][p] = own[p];
              else if (p_mode[d][p] == 1) m_lat[d][p] = old[p];
            end else                 m_lat[d][p] = old[p];
          end
          if (ssr[p])      m_reg[d][p] = p_srval[d][p];
          else if (rce[p]) m_reg[d][p] = prev_lat;
        end
    end
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        exp_q.push_back((p_doreg[d][p] != 0) ? m_reg[d][p] : m_lat[d][p]);
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model, edge, then compare all four outputs against the queue.
  task automatic cycle();
    logic [35:0] obs [0:3];
    model_step();
    @(posedge sys_clk);
    #1;
    cyc++;
    obs[0] = {dopa0, doa0};
    obs[1] = {dopb0, dob0};
    obs[2] = {dopa1, doa1};
    obs[3] = {dopb1, dob1};
    for (int k = 0; k < 4; k++)
      chk($sformatf("model_cyc%0d_out%0d", cyc, k), obs[k], exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic en, input logic [3:0] we, input logic [9:0] w,
                         input logic [31:0] d, input logic ssr, input bit junk);
    ena = en; wea = we; addra = mk_addr(w, junk); dia = d; dipa = 4'h0; ssra = ssr;
  endtask

  task automatic drive_b(input logic en, input logic [3:0] we, input logic [9:0] w,
                         input logic [31:0] d, input logic ssr, input bit junk);
    enb = en; web = we; addrb = mk_addr(w, junk); dib = d; dipb = 4'h0; ssrb = ssr;
  endtask

  task automatic idle();
    drive_a(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 1'b0);
    drive_b(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [9:0] rand_word();
    int pick;
    pick = $urandom_range(0, 8);
    return (pick == 8) ? 10'h3FF : 10'(pick);
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = 36'h0;
    p_init[0][0] = INIT_A0;  p_init[0][1] = INIT_B0;  p_init[1][0] = INIT_A1;  p_init[1][1] = INIT_B1;
    p_srval[0][0] = SRVAL_A0; p_srval[0][1] = SRVAL_B0; p_srval[1][0] = SRVAL_A1; p_srval[1][1] = SRVAL_B1;
    p_mode[0][0] = 0; p_mode[0][1] = 1; p_mode[1][0] = 2; p_mode[1][1] = 0;
    p_doreg[0][0] = 0; p_doreg[0][1] = 0; p_doreg[1][0] = 1; p_doreg[1][1] = 1;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        m_lat[d][p] = 36'h0;
        m_reg[d][p] = 36'h0;
      end

    sys_rst = 1'b1; regcea = 1'b1; regceb = 1'b1;
    idle();
    cycle();
    cycle();
    chk("reset_a0", {dopa0, doa0}, INIT_A0);
    chk("reset_b0", {dopb0, dob0}, INIT_B0);
    chk("reset_a1", {dopa1, doa1}, INIT_A1);
    chk("reset_b1", {dopb1, dob1}, INIT_B1);
    sys_rst = 1'b0;

    // A writes, B reads the same word next cycle.
    drive_a(1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b0, 1'b0);
    cycle();
    chk("wf_a_write", {dopa0, doa0}, 36'h0_DEADBEEF);
    idle();
    drive_b(1'b1, 4'h0, 10'h005, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("b_read_after_a", {dopb0, dob0}, 36'h0_DEADBEEF);
    idle();
    cycle();
    chk("b_read_reg2", {dopb1, dob1}, 36'h0_DEADBEEF);

    // Byte enables on a write-first port.
    drive_a(1'b1, 4'hF, 10'h009, 32'h11223344, 1'b0, 1'b0);
    cycle();
    drive_a(1'b1, 4'b0101, 10'h009, 32'hAABBCCDD, 1'b0, 1'b0);
    cycle();
    chk("byte_en_wf", {dopa0, doa0}, 36'h0_11BB33DD);

    // Read-first on port B.
    idle();
    drive_b(1'b1, 4'hF, 10'd20, 32'h9, 1'b0, 1'b0);
    cycle();
    chk("rf_first_old0", {dopb0, dob0}, 36'h0);
    drive_b(1'b1, 4'hF, 10'd20, 32'h5, 1'b0, 1'b0);
    cycle();
    chk("rf_old9", {dopb0, dob0}, 36'h9);
    drive_b(1'b1, 4'h0, 10'd20, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("rf_read5", {dopb0, dob0}, 36'h5);

    // Collisions on word 7.
    drive_a(1'b1, 4'hF, 10'd7, 32'h1, 1'b0, 1'b0);
    drive_b(1'b1, 4'hF, 10'd7, 32'h2, 1'b0, 1'b0);
    cycle();
    drive_a(1'b1, 4'hF, 10'd7, 32'h3, 1'b0, 1'b0);
    drive_b(1'b1, 4'h0, 10'd7, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("coll_b_wins_old", {dopb0, dob0}, 36'h2);
    chk("coll_a_wf", {dopa0, doa0}, 36'h3);
    drive_a(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("coll_readback", {dopb0, dob0}, 36'h3);

    // Synchronous set/reset while reading nonzero data.
    idle();
    drive_b(1'b1, 4'h0, 10'h005, 32'h0, 1'b1, 1'b0);
    cycle();
    chk("ssrb_lat", {dopb0, dob0}, SRVAL_B0);
    chk("ssrb_reg", {dopb1, dob1}, SRVAL_B1);

    // Reset mid-operation: write suppressed, array kept.
    idle();
    sys_rst = 1'b1;
    drive_a(1'b1, 4'hF, 10'h005, 32'h0BAD0BAD, 1'b0, 1'b0);
    cycle();
    chk("midrst_a0", {dopa0, doa0}, INIT_A0);
    chk("midrst_b0", {dopb0, dob0}, INIT_B0);
    chk("midrst_a1", {dopa1, doa1}, INIT_A1);
    sys_rst = 1'b0;
    drive_a(1'b1, 4'h0, 10'h005, 32'h0, 1'b0, 1'b0);
    cycle();
    chk("after_rst_data", {dopa0, doa0}, 36'h0_DEADBEEF);

    // Registered port A: 2-cycle latency, regcea=0 holds.
    drive_a(1'b1, 4'h0, 10'h009, 32'h0, 1'b0, 1'b0);
    cycle();
    idle();
    cycle();
    chk("doa_reg_lat2", {dopa1, doa1}, 36'h0_11BB33DD);
    regcea = 1'b0;
    drive_a(1'b1, 4'h0, 10'h005, 32'h0, 1'b0, 1'b0);
    cycle();
    idle();
    cycle();
    chk("doa_reg_hold", {dopa1, doa1}, 36'h0_11BB33DD);
    regcea = 1'b1;
    cycle();
    chk("doa_reg_load", {dopa1, doa1}, 36'h0_DEADBEEF);

    // Ignored address bits and top/bottom word independence.
    drive_a(1'b1, 4'hF, 10'h3FF, 32'h003FF3FF, 1'b0, 1'b1);
    cycle();
    drive_a(1'b1, 4'hF, 10'h000, 32'h12345678, 1'b0, 1'b1);
    cycle();
    idle();
    drive_b(1'b1, 4'h0, 10'h3FF, 32'h0, 1'b0, 1'b1);
    cycle();
    chk("alias_top", {dopb0, dob0}, 36'h0_003FF3FF);
    drive_b(1'b1, 4'h0, 10'h000, 32'h0, 1'b0, 1'b1);
    cycle();
    chk("alias_zero", {dopb0, dob0}, 36'h0_12345678);

    // Randomized traffic on a small word pool so collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      sys_rst = ($urandom_range(0, 31) == 0);
      drive_a($urandom_range(0, 3) != 0, 4'($urandom), rand_word(), $urandom,
              $urandom_range(0, 7) == 0, 1'b1);
      dipa = 4'($urandom);
      drive_b($urandom_range(0, 3) != 0, 4'($urandom), rand_word(), $urandom,
              $urandom_range(0, 7) == 0, 1'b1);
      dipb = 4'($urandom);
      regcea = ($urandom_range(0, 3) != 0);
      regceb = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
